// File: rtl/glyph_banner_seq.sv
// Banner animation sequencer for per-letter glyph renderers.
// Runs a typewriter reveal, a blink, a solid hold and then a clear, all paced by frame_tick.
// Optional slide-in of y0 is compiled in when GLYPH_BANNER_SLIDE_EN is defined.
module glyph_banner_seq #(
  parameter int unsigned NUM_GLYPHS    = 8,
  parameter int unsigned REVEAL_FRAMES = 6,
  parameter int unsigned BLINK_FRAMES  = 15,
  parameter int unsigned BLINK_COUNT   = 3,
  parameter int unsigned HOLD_FRAMES   = 60,
  parameter int unsigned START_Y       = 0,
  parameter int unsigned SLIDE_STEP    = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  frame_tick,
  input  logic                  start,
  input  logic                  abort,
  input  logic [3:0]            msg_len,
  input  logic [9:0]            target_y,
  output logic [9:0]            y0,
  output logic [NUM_GLYPHS-1:0] glyph_en,
  output logic                  busy,
  output logic                  done
);

  localparam logic [4:0] NumG      = 5'(NUM_GLYPHS);
  localparam logic [7:0] RevLast   = 8'(REVEAL_FRAMES - 1);
  localparam logic [7:0] BlinkLast = 8'(BLINK_FRAMES - 1);
  localparam logic [7:0] HoldLast  = 8'(HOLD_FRAMES - 1);
  // Blink ends once vis has toggled an even number of times, so it is on again.
  localparam logic [7:0] PhaseEnd  = 8'(2 * BLINK_COUNT);

  typedef enum logic [1:0] {StIdle, StReveal, StBlink, StHold} state_e;

  state_e                state_q, state_d;
  logic [7:0]            fcnt_q, fcnt_d;
  logic [7:0]            phase_q, phase_d;
  logic [4:0]            rev_q, rev_d;
  logic [4:0]            len_q, len_d;
  logic                  vis_q, vis_d;
  logic [NUM_GLYPHS-1:0] glyph_en_q, glyph_en_d;
  logic [9:0]            y0_q, y0_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic [4:0]            len_clamped;

  // Low n bits set.
  function automatic logic [NUM_GLYPHS-1:0] mask_of(input logic [4:0] n);
    logic [NUM_GLYPHS-1:0] m;
    for (int k = 0; k < NUM_GLYPHS; k++) begin
      m[k] = (5'(k) < n);
    end
    return m;
  endfunction

`ifdef GLYPH_BANNER_SLIDE_EN
  logic [9:0]  tgt_q, tgt_d;
  logic [10:0] y_sum;
  logic [9:0]  y_start;
`else
  // Slide configuration only matters when the slide feature is built in.
  logic unused_slide_cfg;
  assign unused_slide_cfg = ^{10'(START_Y), 10'(SLIDE_STEP)};
`endif

  // Clamp the requested length into 1..NUM_GLYPHS.
  always_comb begin
    len_clamped = {1'b0, msg_len};
    if (msg_len == 4'd0) begin
      len_clamped = 5'd1;
    end else if ({1'b0, msg_len} > NumG) begin
      len_clamped = NumG;
    end
  end

`ifdef GLYPH_BANNER_SLIDE_EN
  // Saturating slide arithmetic and start position.
  always_comb begin
    y_sum   = {1'b0, y0_q} + 11'(SLIDE_STEP);
    y_start = (11'(START_Y) >= {1'b0, target_y}) ? target_y : 10'(START_Y);
  end
`endif

  // Next-state and registered-output logic.
  always_comb begin
    state_d    = state_q;
    fcnt_d     = fcnt_q;
    phase_d    = phase_q;
    rev_d      = rev_q;
    len_d      = len_q;
    vis_d      = vis_q;
    glyph_en_d = glyph_en_q;
    y0_d       = y0_q;
    done_d     = 1'b0;
`ifdef GLYPH_BANNER_SLIDE_EN
    tgt_d      = tgt_q;
`endif

    if (state_q == StIdle) begin
      glyph_en_d = '0;
      if (start && !abort) begin
        state_d = StReveal;
        len_d   = len_clamped;
        fcnt_d  = 8'd0;
        phase_d = 8'd0;
        rev_d   = 5'd0;
        vis_d   = 1'b0;
`ifdef GLYPH_BANNER_SLIDE_EN
        tgt_d   = target_y;
        y0_d    = y_start;
`else
        y0_d    = target_y;
`endif
      end
    end else if (abort) begin
      state_d    = StIdle;
      glyph_en_d = '0;
    end else if (frame_tick) begin
`ifdef GLYPH_BANNER_SLIDE_EN
      y0_d = (y_sum >= {1'b0, tgt_q}) ? tgt_q : y_sum[9:0];
`endif
      unique case (state_q)
        StReveal: begin
          if (fcnt_q == RevLast) begin
            fcnt_d = 8'd0;
            for (int k = 0; k < NUM_GLYPHS; k++) begin
              if (5'(k) == rev_q) glyph_en_d[k] = 1'b1;
            end
            rev_d = rev_q + 5'd1;
            if (rev_q + 5'd1 >= len_q) begin
              state_d = StBlink;
              vis_d   = 1'b1;
              phase_d = 8'd0;
            end
          end else begin
            fcnt_d = fcnt_q + 8'd1;
          end
        end
        StBlink: begin
          if (fcnt_q == BlinkLast) begin
            fcnt_d  = 8'd0;
            vis_d   = ~vis_q;
            phase_d = phase_q + 8'd1;
            if (phase_q + 8'd1 == PhaseEnd) begin
              state_d = StHold;
            end
          end else begin
            fcnt_d = fcnt_q + 8'd1;
          end
          glyph_en_d = vis_d ? mask_of(len_q) : '0;
        end
        StHold: begin
          glyph_en_d = mask_of(len_q);
          if (fcnt_q == HoldLast) begin
            state_d    = StIdle;
            glyph_en_d = '0;
            done_d     = 1'b1;
            fcnt_d     = 8'd0;
          end else begin
            fcnt_d = fcnt_q + 8'd1;
          end
        end
        default: begin
          state_d = StIdle;
        end
      endcase
    end

    busy_d = (state_d != StIdle);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      fcnt_q     <= 8'd0;
      phase_q    <= 8'd0;
      rev_q      <= 5'd0;
      len_q      <= 5'd0;
      vis_q      <= 1'b0;
      glyph_en_q <= '0;
      y0_q       <= 10'd0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      fcnt_q     <= fcnt_d;
      phase_q    <= phase_d;
      rev_q      <= rev_d;
      len_q      <= len_d;
      vis_q      <= vis_d;
      glyph_en_q <= glyph_en_d;
      y0_q       <= y0_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

`ifdef GLYPH_BANNER_SLIDE_EN
  // Latched slide destination.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tgt_q <= 10'd0;
    end else begin
      tgt_q <= tgt_d;
    end
  end
`endif

  assign y0       = y0_q;
  assign glyph_en = glyph_en_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_glyph_banner_seq.sv
// Bench for glyph_banner_seq: a tick-count model of the banner timeline checked every cycle,
// plus literal expectations taken from hand-worked sequences.
module tb_glyph_banner_seq;

  localparam int NG = 8;
  localparam int RF = 2;
  localparam int BF = 1;
  localparam int BC = 1;
  localparam int HF = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          frame_tick = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [3:0]    msg_len = 4'd0;
  logic [9:0]    target_y = 10'd0;
  logic [9:0]    y0;
  logic [NG-1:0] glyph_en;
  logic          busy;
  logic          done;

  int checks = 0;
  int failures = 0;

  glyph_banner_seq #(
    .NUM_GLYPHS   (NG),
    .REVEAL_FRAMES(RF),
    .BLINK_FRAMES (BF),
    .BLINK_COUNT  (BC),
    .HOLD_FRAMES  (HF),
    .START_Y      (190),
    .SLIDE_STEP   (4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .frame_tick(frame_tick),
    .start     (start),
    .abort     (abort),
    .msg_len   (msg_len),
    .target_y  (target_y),
    .y0        (y0),
    .glyph_en  (glyph_en),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a sequence is just a count of frame ticks since start.
  bit         m_active;
  int         m_len;
  int         m_t;
  logic [9:0] m_y0;
  logic       m_done;

  function automatic logic [NG-1:0] low_bits(input int n);
    logic [NG-1:0] m = '0;
    for (int k = 0; k < n && k < NG; k++) m[k] = 1'b1;
    return m;
  endfunction

  function automatic logic [NG-1:0] model_en(input bit act, input int len, input int t);
    int u;
    if (!act) return '0;
    if (t < len * RF) return low_bits(t / RF);
    u = t - len * RF;
    if (u < 2 * BC * BF) return (((u / BF) % 2) == 0) ? low_bits(len) : '0;
    return low_bits(len);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_active = 1'b0;
      m_len    = 0;
      m_t      = 0;
      m_y0     = '0;
      m_done   = 1'b0;
    end else begin
      m_done = 1'b0;
      if (m_active) begin
        if (abort) begin
          m_active = 1'b0;
        end else if (frame_tick) begin
          m_t++;
          if (m_t == m_len * RF + 2 * BC * BF + HF) begin
            m_active = 1'b0;
            m_done   = 1'b1;
          end
        end
      end else if (start && !abort) begin
        m_active = 1'b1;
        m_t      = 0;
        m_len    = (msg_len == 0) ? 1 : ((int'(msg_len) > NG) ? NG : int'(msg_len));
        m_y0     = target_y;
      end
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    chk("cyc_glyph_en", 32'(glyph_en), 32'(model_en(m_active, m_len, m_t)));
    chk("cyc_busy", 32'(busy), 32'(m_active));
    chk("cyc_done", 32'(done), 32'(m_done));
    chk("cyc_y0", 32'(y0), 32'(m_y0));
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic tick();
    frame_tick = 1'b1;
    cyc();
    frame_tick = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      cyc();
    end
  endtask

  task automatic do_start(input logic [3:0] len, input logic [9:0] ty);
    msg_len  = len;
    target_y = ty;
    start    = 1'b1;
    cyc();
    start = 1'b0;
  endtask

  // Runs the last n ticks of a sequence and pins the done pulse on the final one.
  task automatic finish_seq(input int n);
    ticks(n - 1);
    tick();
    chk("finish_done", 32'(done), 32'd1);
    chk("finish_en", 32'(glyph_en), 32'd0);
    chk("finish_busy", 32'(busy), 32'd0);
  endtask

  logic [7:0] seq [11];

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    seq = '{8'h00, 8'h01, 8'h01, 8'h03, 8'h03, 8'h07, 8'h00, 8'h07, 8'h07, 8'h07, 8'h00};
    cyc();
    cyc();
    chk("reset_en", 32'(glyph_en), 32'd0);
    chk("reset_y0", 32'(y0), 32'd0);
    rst_n = 1'b1;
    cyc();
    chk("idle_busy", 32'(busy), 32'd0);

    // Main timeline, len=3, y0=200.
    do_start(4'd3, 10'd200);
    chk("start_busy", 32'(busy), 32'd1);
    chk("start_y0", 32'(y0), 32'd200);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk($sformatf("seq_tick%0d", i + 1), 32'(glyph_en), 32'(seq[i]));
      chk("seq_y0", 32'(y0), 32'd200);
      cyc();
    end
    tick();
    chk("seq_tick11", 32'(glyph_en), 32'(seq[10]));
    chk("seq_done", 32'(done), 32'd1);
    chk("seq_busy", 32'(busy), 32'd0);
    // Start arriving in the done cycle is accepted.
    do_start(4'd2, 10'd300);
    chk("restart_busy", 32'(busy), 32'd1);
    chk("restart_done_gone", 32'(done), 32'd0);
    chk("restart_y0", 32'(y0), 32'd300);
    finish_seq(2 * RF + 2 * BC * BF + HF);
    cyc();

    // msg_len 0 behaves as a single glyph.
    do_start(4'd0, 10'd10);
    ticks(2);
    chk("len0_en", 32'(glyph_en), 32'h1);
    finish_seq(5);
    cyc();

    // msg_len above NUM_GLYPHS clamps to a full mask.
    do_start(4'd12, 10'd50);
    ticks(16);
    chk("len12_en", 32'(glyph_en), 32'hFF);
    finish_seq(5);
    cyc();

    // Abort together with a tick after tick 4.
    do_start(4'd3, 10'd200);
    ticks(4);
    chk("pre_abort_en", 32'(glyph_en), 32'h3);
    abort      = 1'b1;
    frame_tick = 1'b1;
    cyc();
    abort      = 1'b0;
    frame_tick = 1'b0;
    chk("abort_en", 32'(glyph_en), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    ticks(3);
    chk("abort_idle_done", 32'(done), 32'd0);
    do_start(4'd3, 10'd200);
    chk("abort_restart_en", 32'(glyph_en), 32'd0);
    ticks(2);
    chk("abort_restart_first", 32'(glyph_en), 32'h1);
    finish_seq(9);
    cyc();

    // Start while busy is ignored.
    do_start(4'd3, 10'd200);
    ticks(1);
    msg_len  = 4'd5;
    target_y = 10'd100;
    start    = 1'b1;
    cyc();
    start = 1'b0;
    ticks(5);
    chk("ignore_en", 32'(glyph_en), 32'h7);
    chk("ignore_y0", 32'(y0), 32'd200);
    finish_seq(5);
    cyc();

    // Asynchronous reset in BLINK.
    do_start(4'd3, 10'd200);
    ticks(6);
    chk("blink_en", 32'(glyph_en), 32'h7);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_en", 32'(glyph_en), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_y0", 32'(y0), 32'd0);
    cyc();
    rst_n = 1'b1;
    cyc();
    chk("post_arst_busy", 32'(busy), 32'd0);
    cyc();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
